pd_trace_buffer: RTL and testbench

Parametrised multi-channel commit/probe trace buffer for the pd-series pipeline bench and debug fabric. Captures per-stage probe events (F/D/E/M/W by default) from a non-stallable pipeline, timestamps them, serialises them through a round-robin arbiter into a FIFO, and drains them over a valid/ready stream to the trace generator. Generalises single-stage, single-cycle probe sampling: multiple channels, configurable depth, accounting for dropped events.

---
 rtl/pd_trace_pkg.sv | 26 ++
 rtl/pd_trace_buffer_if.sv | 16 +
 rtl/pd_trace_fifo.sv | 47 ++++
 rtl/pd_trace_buffer.sv | 138 +++++++++++++
 tb/tb_pd_trace_buffer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pd_trace_pkg.sv
// Shared types and helpers for the pd-series trace buffer: default widths,
// the drained record layout and the saturating drop-counter adder.
package pd_trace_pkg;

    localparam int PD_NUM_CH = 5;
    localparam int PD_XLEN   = 32;
    localparam int PD_DEPTH  = 16;
    localparam int PD_TS_W   = 16;
    localparam int PD_CH_W   = $clog2(PD_NUM_CH);
    localparam int DROP_W    = 16;

    typedef struct packed {
        logic [PD_CH_W-1:0] ch;
        logic [PD_XLEN-1:0] pc;
        logic [PD_XLEN-1:0] data;
        logic [PD_TS_W-1:0] ts;
    } trace_rec_t;

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input logic [DROP_W-1:0] b);
        logic [DROP_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DROP_W] ? '1 : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/pd_trace_buffer_if.sv
// Valid/ready output stream carrying one timestamped trace record per beat.
interface pd_trace_buffer_if #(
    parameter int CH_W = pd_trace_pkg::PD_CH_W,
    parameter int XLEN = pd_trace_pkg::PD_XLEN,
    parameter int TS_W = pd_trace_pkg::PD_TS_W
);
    logic            out_valid;
    logic            out_ready;
    logic [CH_W-1:0] out_ch;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_data;
    logic [TS_W-1:0] out_ts;

    modport master (output out_valid, out_ch, out_pc, out_data, out_ts, input out_ready);
    modport slave  (input out_valid, out_ch, out_pc, out_data, out_ts, output out_ready);
endinterface

// File: rtl/pd_trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is presented combinationally
// and reads as zero while empty.
module pd_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_en,
    input  logic [W-1:0]  i_wr_data,
    input  logic          i_rd_en,
    output logic [W-1:0]  o_rd_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_wr;
    logic         w_rd;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd      = i_rd_en && !o_empty;
    assign w_wr      = i_wr_en && (!o_full || w_rd);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone define validity and the head is masked when empty.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/pd_trace_buffer.sv
// Multi-channel probe trace buffer: per-channel skid slots, round-robin
// serialisation into a FIFO, valid/ready drain and drop accounting.
module pd_trace_buffer
    import pd_trace_pkg::*;
#(
    parameter int NUM_CH = PD_NUM_CH,
    parameter int XLEN   = PD_XLEN,
    parameter int DEPTH  = PD_DEPTH,
    parameter int TS_W   = PD_TS_W,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_cap_en,
    input  logic [NUM_CH-1:0]      i_ch_valid,
    input  logic [NUM_CH*XLEN-1:0] i_ch_pc,
    input  logic [NUM_CH*XLEN-1:0] i_ch_data,
    pd_trace_buffer_if.master      m_out,
    output logic [LVL_W-1:0]       o_level,
    output logic [DROP_W-1:0]      o_drop_cnt,
    output logic                   o_overflow
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
        logic [TS_W-1:0] ts;
    } slot_t;

    localparam int REC_W = CH_W + $bits(slot_t);

    logic [TS_W-1:0]   r_ts;
    logic [NUM_CH-1:0] r_slot_vld;
    slot_t             r_slot [NUM_CH];
    logic [CH_W-1:0]   r_ptr;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_overflow;

    logic              w_grant;
    logic [CH_W-1:0]   w_grant_idx;
    logic [NUM_CH-1:0] w_grant_vec;
    logic [NUM_CH-1:0] w_load;
    logic [NUM_CH-1:0] w_drop;
    logic [DROP_W-1:0] w_drop_num;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_fifo_rdy;
    logic [REC_W-1:0]  w_wr_data;
    logic [REC_W-1:0]  w_head;

    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] ptr, input int step);
        int s;
        s = int'(ptr) + step;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    assign w_pop      = !w_empty && m_out.out_ready;
    assign w_fifo_rdy = !w_full || w_pop;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_grant_vec = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (w_fifo_rdy && !w_grant && r_slot_vld[rr_idx(r_ptr, k)]) begin
                w_grant     = 1'b1;
                w_grant_idx = rr_idx(r_ptr, k);
            end
        end
        if (w_grant) w_grant_vec[w_grant_idx] = 1'b1;
    end

    // A full slot may reload in the same cycle it hands its record to the FIFO.
    always_comb begin
        w_load     = '0;
        w_drop     = '0;
        w_drop_num = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_cap_en && i_ch_valid[i]) begin
                if (!r_slot_vld[i] || w_grant_vec[i]) w_load[i] = 1'b1;
                else                                  w_drop[i] = 1'b1;
            end
            w_drop_num = w_drop_num + DROP_W'(w_drop[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts       <= '0;
            r_slot_vld <= '0;
            r_ptr      <= CH_W'(NUM_CH - 1);
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_ts       <= r_ts + TS_W'(1);
            r_slot_vld <= (r_slot_vld & ~w_grant_vec) | w_load;
            if (w_grant) r_ptr <= w_grant_idx;
            r_drop_cnt <= sat_add(r_drop_cnt, w_drop_num);
            if (|w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_load[i]) begin
                r_slot[i] <= '{pc:   i_ch_pc[i*XLEN +: XLEN],
                               data: i_ch_data[i*XLEN +: XLEN],
                               ts:   r_ts};
            end
        end
    end

    assign w_wr_data = {w_grant_idx, r_slot[w_grant_idx]};

    pd_trace_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .i_wr_en   (w_grant),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (o_level)
    );

    assign m_out.out_valid = !w_empty;
    assign {m_out.out_ch, m_out.out_pc, m_out.out_data, m_out.out_ts} = w_head;
    assign o_drop_cnt      = r_drop_cnt;
    assign o_overflow      = r_overflow;

endmodule

// File: tb/tb_pd_trace_buffer.sv
// Directed bench for pd_trace_buffer: expected records are queued when stimulus
// is driven and compared as each beat is accepted on the output stream.
module tb_pd_trace_buffer;
    import pd_trace_pkg::*;

    localparam int NUM_CH = 5;
    localparam int XLEN   = 32;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;
    localparam int CH_W   = 3;
    localparam int LVL_W  = 5;

    logic                   clk      = 1'b0;
    logic                   reset    = 1'b0;
    logic                   cap_en   = 1'b0;
    logic [NUM_CH-1:0]      ch_valid = '0;
    logic [NUM_CH*XLEN-1:0] ch_pc    = '0;
    logic [NUM_CH*XLEN-1:0] ch_data  = '0;
    logic [LVL_W-1:0]       level;
    logic [15:0]            drop_cnt;
    logic                   overflow;
    logic [TS_W-1:0]        tb_ts;

    trace_rec_t sb [$];
    int n_checks = 0;
    int n_fail   = 0;

    pd_trace_buffer_if #(.CH_W(CH_W), .XLEN(XLEN), .TS_W(TS_W)) u_if ();

    pd_trace_buffer #(
        .NUM_CH (NUM_CH),
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .TS_W   (TS_W)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .i_cap_en   (cap_en),
        .i_ch_valid (ch_valid),
        .i_ch_pc    (ch_pc),
        .i_ch_data  (ch_data),
        .m_out      (u_if),
        .o_level    (level),
        .o_drop_cnt (drop_cnt),
        .o_overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference timestamp: zero in reset, +1 per edge otherwise.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_ts <= '0;
        else        tb_ts <= tb_ts + 16'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic trace_rec_t mk(input int ch, input logic [31:0] pc,
                                      input logic [31:0] data, input logic [15:0] ts);
        trace_rec_t r;
        r.ch   = 3'(ch);
        r.pc   = pc;
        r.data = data;
        r.ts   = ts;
        return r;
    endfunction

    // One clock: check any beat accepted at the coming edge, then return just after it.
    task automatic step();
        @(negedge clk);
        if (u_if.out_valid && u_if.out_ready) begin
            trace_rec_t obs;
            trace_rec_t exp;
            obs.ch   = u_if.out_ch;
            obs.pc   = u_if.out_pc;
            obs.data = u_if.out_data;
            obs.ts   = u_if.out_ts;
            check("sb_has_entry", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("record", 128'(obs), 128'(exp));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [31:0] pc, input logic [31:0] data);
        ch_valid[i]             = 1'b1;
        ch_pc[i*XLEN +: XLEN]   = pc;
        ch_data[i*XLEN +: XLEN] = data;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] t0;
        u_if.out_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_valid",    128'(u_if.out_valid), 128'(0));
        check("rst_level",    128'(level),          128'(0));
        check("rst_drop",     128'(drop_cnt),       128'(0));
        check("rst_overflow", 128'(overflow),       128'(0));
        check("rst_head", 128'({u_if.out_ch, u_if.out_pc, u_if.out_data, u_if.out_ts}), 128'(0));
        reset = 1'b1;

        // Single event captured at ts=3
        u_if.out_ready = 1'b1;
        cap_en         = 1'b1;
        step();
        step();
        step();
        set_ch(0, 32'h100, 32'hAA);
        sb.push_back(mk(0, 32'h100, 32'hAA, 16'd3));
        step();
        ch_valid = '0;
        check("single_not_yet_valid", 128'(u_if.out_valid), 128'(0));
        step();
        check("single_valid", 128'(u_if.out_valid), 128'(1));
        check("single_level", 128'(level),          128'(1));
        step();
        check("single_drained", 128'(level), 128'(0));
        check("single_sb_empty", 128'(sb.size()), 128'(0));

        // All channels in one cycle: drained 0..4 on consecutive beats
        do_reset();
        t0 = tb_ts;
        for (int i = 0; i < NUM_CH; i++) begin
            set_ch(i, 32'(16 * i), 32'(8'hD0 + i));
            sb.push_back(mk(i, 32'(16 * i), 32'(8'hD0 + i), t0));
        end
        step();
        ch_valid = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            step();
            check("all_ch_valid_beat", 128'(u_if.out_valid), 128'(1));
        end
        step();
        check("all_ch_sb_empty", 128'(sb.size()), 128'(0));
        check("all_ch_level",    128'(level),     128'(0));
        check("all_ch_drop",     128'(drop_cnt),  128'(0));

        // Round-robin between channels 1 and 3, each valid every cycle
        t0 = tb_ts;
        for (int j = 0; j < 9; j++) begin
            int ch;
            int off;
            ch  = (j % 2 == 0) ? 1 : 3;
            off = (j == 0) ? 0 : j - 1;
            sb.push_back(mk(ch, 32'(32'h1000 * ch + off), ~32'(32'h1000 * ch + off), t0 + 16'(off)));
        end
        for (int n = 0; n < 8; n++) begin
            set_ch(1, 32'(32'h1000 + n), ~32'(32'h1000 + n));
            set_ch(3, 32'(32'h3000 + n), ~32'(32'h3000 + n));
            step();
            check("rr_drop_cnt", 128'(drop_cnt), 128'(n));
        end
        ch_valid = '0;
        repeat (4) step();
        check("rr_sb_empty", 128'(sb.size()), 128'(0));
        check("rr_level",    128'(level),     128'(0));
        check("rr_drop_end", 128'(drop_cnt),  128'(7));
        check("rr_overflow", 128'(overflow),  128'(1));

        // Fill under backpressure, then push/pop at full
        do_reset();
        u_if.out_ready = 1'b0;
        t0 = tb_ts;
        for (int n = 0; n < 20; n++) begin
            set_ch(0, 32'(32'h2000 + n), ~32'(32'h2000 + n));
            if (n <= 16) sb.push_back(mk(0, 32'(32'h2000 + n), ~32'(32'h2000 + n), t0 + 16'(n)));
            step();
        end
        ch_valid = '0;
        check("full_level",    128'(level),          128'(16));
        check("full_drop",     128'(drop_cnt),       128'(3));
        check("full_overflow", 128'(overflow),       128'(1));
        check("full_valid",    128'(u_if.out_valid), 128'(1));
        check("full_head_ts",  128'(u_if.out_ts),    128'(t0));
        step();
        check("hold_head_ts", 128'(u_if.out_ts), 128'(t0));
        check("hold_level",   128'(level),       128'(16));
        u_if.out_ready = 1'b1;
        step();
        check("pushpop_level",   128'(level),       128'(16));
        check("pushpop_head_ts", 128'(u_if.out_ts), 128'(t0 + 16'd1));
        check("pushpop_drop",    128'(drop_cnt),    128'(3));
        repeat (16) step();
        check("full_sb_empty",    128'(sb.size()), 128'(0));
        check("full_drain_level", 128'(level),     128'(0));

        // Async reset with eight records queued, then capture disabled
        u_if.out_ready = 1'b0;
        for (int n = 0; n < 9; n++) begin
            set_ch(0, 32'(32'h5000 + n), 32'(n));
            step();
        end
        ch_valid = '0;
        check("pre_reset_level", 128'(level), 128'(8));
        #2;
        reset = 1'b0;
        #1;
        check("async_valid",    128'(u_if.out_valid), 128'(0));
        check("async_level",    128'(level),          128'(0));
        check("async_drop",     128'(drop_cnt),       128'(0));
        check("async_overflow", 128'(overflow),       128'(0));
        step();
        step();
        reset          = 1'b1;
        cap_en         = 1'b0;
        u_if.out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NUM_CH; i++) set_ch(i, 32'(32'h7000 + i), 32'(n));
            step();
            check("capoff_valid", 128'(u_if.out_valid), 128'(0));
            check("capoff_level", 128'(level),          128'(0));
            check("capoff_drop",  128'(drop_cnt),       128'(0));
        end
        ch_valid = '0;
        check("capoff_overflow", 128'(overflow), 128'(0));
        check("final_sb_empty",  128'(sb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
